// File: rtl/tmds_decoder_if.sv
// Word-level link between one TMDS channel deserializer and its decoder:
// the received word goes in, alignment control and decoded pixel data come back.
interface tmds_decoder_if #(
    parameter int ERR_W = 16
);
    logic [9:0]       TMDS;
    logic             bitslip;
    logic             locked;
    logic [7:0]       VD;
    logic [1:0]       CD;
    logic             VDE;
    logic             lock_lost;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output TMDS,
        input  bitslip, locked, VD, CD, VDE, lock_lost, err_cnt
    );

    modport slave (
        input  TMDS,
        output bitslip, locked, VD, CD, VDE, lock_lost, err_cnt
    );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS channel receiver: hunts word alignment on control-token runs, then
// decodes each 10-bit word to 8-bit video or 2-bit control data.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_SEARCH    | unaligned, counting token run, bitslip after SEARCH_WIN
// ST_SLIP_WAIT | deserializer settling after a bitslip, input ignored
// ST_LOCKED    | aligned, decoding; needs a fresh token run every LOCK_TIMEOUT
module tmds_decoder #(
    parameter int LOCK_TOKENS  = 8,
    parameter int SEARCH_WIN   = 1024,
    parameter int SLIP_WAIT    = 16,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int ERR_W        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    tmds_decoder_if.slave bus
);
    localparam int TMR_MAX = (SEARCH_WIN > LOCK_TIMEOUT)
                           ? ((SEARCH_WIN > SLIP_WAIT) ? SEARCH_WIN : SLIP_WAIT)
                           : ((LOCK_TIMEOUT > SLIP_WAIT) ? LOCK_TIMEOUT : SLIP_WAIT);
    localparam int TMR_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int RUN_W = $clog2(LOCK_TOKENS + 1);

    localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_WIN - 1);
    localparam logic [TMR_W-1:0] SLIP_LAST   = TMR_W'(SLIP_WAIT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(LOCK_TOKENS);

    typedef enum logic [1:0] {
        ST_SEARCH    = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [RUN_W-1:0] run_q, run_d, run_tok;
    logic             is_token;
    logic [1:0]       tok_cd;
    logic [7:0]       d_word, vd_dec;
    logic             run_full, run_first;

    logic             bitslip_d, lock_lost_d, vde_d;
    logic [7:0]       vd_d;
    logic [1:0]       cd_d;
    logic             bitslip_q, lock_lost_q, vde_q;
    logic [7:0]       vd_q;
    logic [1:0]       cd_q;
    logic [ERR_W-1:0] err_q;

    always_comb begin
        is_token = 1'b1;
        tok_cd   = 2'b00;
        case (bus.TMDS)
            10'b1101010100: tok_cd = 2'b00;
            10'b0010101011: tok_cd = 2'b01;
            10'b0101010100: tok_cd = 2'b10;
            10'b1010101011: tok_cd = 2'b11;
            default:        is_token = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    assign d_word = bus.TMDS[9] ? ~bus.TMDS[7:0] : bus.TMDS[7:0];
    assign vd_dec = {d_word[7:1] ^ d_word[6:0] ^ {7{~bus.TMDS[8]}}, d_word[0]};

    assign run_tok   = !is_token ? '0 : ((run_q == RUN_FULL) ? run_q : run_q + 1'b1);
    assign run_full  = (run_tok == RUN_FULL);
    assign run_first = run_full && (run_q != RUN_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_SEARCH;
            timer_q     <= '0;
            run_q       <= '0;
            bitslip_q   <= 1'b0;
            lock_lost_q <= 1'b0;
            vde_q       <= 1'b0;
            vd_q        <= '0;
            cd_q        <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            run_q       <= run_d;
            bitslip_q   <= bitslip_d;
            lock_lost_q <= lock_lost_d;
            vde_q       <= vde_d;
            vd_q        <= vd_d;
            cd_q        <= cd_d;
            if (lock_lost_d && (err_q != '1))
                err_q <= err_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        run_d   = run_tok;
        case (state_q)
            ST_SEARCH: begin
                // A completed run outranks the window expiring on the same cycle.
                if (run_full) begin
                    state_d = ST_LOCKED;
                    timer_d = '0;
                end else if (timer_q == SEARCH_LAST) begin
                    state_d = ST_SLIP_WAIT;
                    timer_d = '0;
                    run_d   = '0;
                end
            end
            ST_SLIP_WAIT: begin
                run_d = '0;
                if (timer_q == SLIP_LAST) begin
                    state_d = ST_SEARCH;
                    timer_d = '0;
                end
            end
            ST_LOCKED: begin
                if (run_first) begin
                    timer_d = '0;
                end else if (timer_q == LOCK_LAST) begin
                    state_d = ST_SEARCH;
                    timer_d = '0;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                timer_d = '0;
                run_d   = '0;
            end
        endcase
    end

    always_comb begin
        bitslip_d   = (state_q == ST_SEARCH) && (state_d == ST_SLIP_WAIT);
        lock_lost_d = (state_q == ST_LOCKED) && (state_d == ST_SEARCH);
        vde_d       = 1'b0;
        vd_d        = '0;
        cd_d        = '0;
        if (state_q == ST_LOCKED) begin
            vde_d = !is_token;
            if (is_token)
                cd_d = tok_cd;
            else
                vd_d = vd_dec;
        end
    end

    assign bus.bitslip   = bitslip_q;
    assign bus.locked    = (state_q == ST_LOCKED);
    assign bus.VD        = vd_q;
    assign bus.CD        = cd_q;
    assign bus.VDE       = vde_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: directed alignment/decoding scenarios plus random
// token/data streams, all checked against a behavioural receiver model.
module tb_tmds_decoder;
    localparam int LT    = 4;
    localparam int SW    = 32;
    localparam int SLW   = 4;
    localparam int LTO   = 64;
    localparam int ERR_W = 16;

    localparam logic [9:0] CTL0 = 10'b1101010100;
    localparam logic [9:0] CTL1 = 10'b0010101011;
    localparam logic [9:0] CTL2 = 10'b0101010100;
    localparam logic [9:0] CTL3 = 10'b1010101011;

    logic clk;
    logic rst_n;
    bit   cmp_en;
    int   n_chk;
    int   n_err;
    int   enc_cnt;

    tmds_decoder_if #(.ERR_W(ERR_W)) bus();

    tmds_decoder #(
        .LOCK_TOKENS (LT),
        .SEARCH_WIN  (SW),
        .SLIP_WAIT   (SLW),
        .LOCK_TIMEOUT(LTO),
        .ERR_W       (ERR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transition-minimised stage of the encoder for a given XOR/XNOR choice.
    function automatic logic [8:0] qm_of(input logic [7:0] b, input bit use_xor);
        logic [8:0] q;
        q[0] = b[0];
        for (int i = 1; i < 8; i++)
            q[i] = use_xor ? (q[i-1] ^ b[i]) : ~(q[i-1] ^ b[i]);
        q[8] = use_xor;
        return q;
    endfunction

    // Full DVI transmitter encoder including running disparity.
    function automatic logic [9:0] tmds_encode(input logic [7:0] b);
        int n1b, n1q, n0q;
        logic [8:0] q;
        logic [9:0] o;
        n1b = $countones(b);
        q = qm_of(b, !((n1b > 4) || (n1b == 4 && b[0] == 1'b0)));
        n1q = $countones(q[7:0]);
        n0q = 8 - n1q;
        if (enc_cnt == 0 || n1q == n0q) begin
            o = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            enc_cnt += q[8] ? (n1q - n0q) : (n0q - n1q);
        end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
            o = {1'b1, q[8], ~q[7:0]};
            enc_cnt += (q[8] ? 2 : 0) + (n0q - n1q);
        end else begin
            o = {1'b0, q[8], q[7:0]};
            enc_cnt += (q[8] ? 0 : -2) + (n1q - n0q);
        end
        return o;
    endfunction

    // Reference decode is the inverse of the encoder, built as a lookup table.
    logic [7:0] inv_tab [2][256];

    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] d;
        d = w[9] ? ~w[7:0] : w[7:0];
        return inv_tab[w[8]][d];
    endfunction

    function automatic logic [2:0] ctl_lookup(input logic [9:0] w);
        case (w)
            CTL0:    return 3'b100;
            CTL1:    return 3'b101;
            CTL2:    return 3'b110;
            CTL3:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [9:0] rot(input logic [9:0] w, input int k);
        logic [19:0] x;
        x = {w, w} >> k;
        return x[9:0];
    endfunction

    // Behavioural receiver: mode, token run length and cycles spent in mode.
    localparam int M_SEARCH = 0;
    localparam int M_WAIT   = 1;
    localparam int M_LOCKED = 2;
    int         m_mode, m_run, m_age, nrun;
    logic [2:0] m_c;
    bit         e_gate, e_locked, e_bitslip, e_lost, e_vde;
    logic [7:0] e_vd;
    logic [1:0] e_cd;
    logic [15:0] e_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_SEARCH; m_run = 0; m_age = 0;
            e_gate = 0; e_locked = 0; e_bitslip = 0; e_lost = 0; e_vde = 0;
            e_vd = 8'h00; e_cd = 2'b00; e_err = 16'h0000;
        end else begin
            m_c    = ctl_lookup(bus.TMDS);
            e_gate = (m_mode == M_LOCKED);
            e_vde  = e_gate && !m_c[2];
            e_vd   = e_vde ? ref_decode(bus.TMDS) : 8'h00;
            e_cd   = (e_gate && m_c[2]) ? m_c[1:0] : 2'b00;
            nrun   = m_c[2] ? ((m_run < LT) ? m_run + 1 : LT) : 0;
            e_bitslip = 0;
            e_lost    = 0;
            if (m_mode == M_SEARCH) begin
                if (nrun == LT) begin
                    m_mode = M_LOCKED; m_age = 0;
                end else if (m_age == SW - 1) begin
                    m_mode = M_WAIT; m_age = 0; nrun = 0; e_bitslip = 1;
                end else m_age++;
            end else if (m_mode == M_WAIT) begin
                nrun = 0;
                if (m_age == SLW - 1) begin
                    m_mode = M_SEARCH; m_age = 0;
                end else m_age++;
            end else begin
                if (nrun == LT && m_run < LT) m_age = 0;
                else if (m_age == LTO - 1) begin
                    m_mode = M_SEARCH; m_age = 0; nrun = 0; e_lost = 1;
                    if (e_err != 16'hFFFF) e_err++;
                end else m_age++;
            end
            m_run    = nrun;
            e_locked = (m_mode == M_LOCKED);
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("m_locked", bus.locked, e_locked);
            chk("m_bitslip", bus.bitslip, e_bitslip);
            chk("m_lock_lost", bus.lock_lost, e_lost);
            chk("m_err_cnt", bus.err_cnt, e_err);
            chk("m_vde", bus.VDE, e_vde);
            if (e_vde || !e_gate) chk("m_vd", bus.VD, e_vd);
            if (!e_vde) chk("m_cd", bus.CD, e_cd);
        end
    end

    task automatic drive(input logic [9:0] w);
        bus.TMDS = w;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_locked"}, bus.locked, 0);
        chk({tag, "_bitslip"}, bus.bitslip, 0);
        chk({tag, "_lock_lost"}, bus.lock_lost, 0);
        chk({tag, "_vd"}, bus.VD, 0);
        chk({tag, "_cd"}, bus.CD, 0);
        chk({tag, "_vde"}, bus.VDE, 0);
        chk({tag, "_err_cnt"}, bus.err_cnt, 0);
    endtask

    logic [9:0] ctl_words [4];
    logic [7:0] bytes [4];
    logic [8:0] qtmp;
    int offset, nslip, lock_at, kind, len;
    int slip_at [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_err = 0; enc_cnt = 0; cmp_en = 0;
        bus.TMDS = '0;
        rst_n = 1'b1;
        ctl_words[0] = CTL0; ctl_words[1] = CTL1; ctl_words[2] = CTL2; ctl_words[3] = CTL3;
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h55; bytes[3] = 8'hA5;
        for (int m = 0; m < 2; m++)
            for (int b = 0; b < 256; b++) begin
                qtmp = qm_of(8'(b), m[0]);
                inv_tab[m][qtmp[7:0]] = 8'(b);
            end

        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1;

        // Aligned token run locks on the 4th word; the 4th word itself decodes to 0.
        for (int i = 1; i <= 4; i++) begin
            drive(CTL0);
            if (i == 3) chk("t1_locked_early", bus.locked, 0);
        end
        chk("t1_locked", bus.locked, 1);
        chk("t1_vde_4th", bus.VDE, 0);
        chk("t1_cd_4th", bus.CD, 0);
        drive(CTL3);
        chk("t1_vde", bus.VDE, 0);
        chk("t1_cd", bus.CD, 2'b11);

        for (int i = 0; i < 4; i++) begin
            drive(tmds_encode(bytes[i]));
            chk("t2_vd", bus.VD, bytes[i]);
            chk("t2_vde", bus.VDE, 1);
        end

        // Lock then data only: timeout after 64 locked cycles.
        do_reset();
        repeat (4) drive(CTL0);
        for (int i = 1; i <= 64; i++) begin
            drive(tmds_encode(8'($urandom_range(0, 255))));
            if (i == 63) begin
                chk("t4_lost_early", bus.lock_lost, 0);
                chk("t4_locked_early", bus.locked, 1);
            end
        end
        chk("t4_lock_lost", bus.lock_lost, 1);
        chk("t4_locked", bus.locked, 0);
        chk("t4_err_cnt", bus.err_cnt, 1);
        drive(tmds_encode(8'h81));
        chk("t4_lost_once", bus.lock_lost, 0);
        chk("t4_vde_gated", bus.VDE, 0);
        chk("t4_vd_gated", bus.VD, 0);
        chk("t4_err_hold", bus.err_cnt, 1);

        // Run completes exactly when the search window expires: lock, no slip.
        repeat (27) drive(tmds_encode(8'($urandom_range(0, 255))));
        for (int i = 1; i <= 4; i++) begin
            drive(CTL0);
            if (i == 3) chk("t5_locked_early", bus.locked, 0);
        end
        chk("t5_locked", bus.locked, 1);
        chk("t5_no_bitslip", bus.bitslip, 0);
        drive(tmds_encode(8'h5A));
        drive(tmds_encode(8'hC3));
        chk("t5_vd", bus.VD, 8'hC3);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t5_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Stream rotated by 3 bits; each bitslip moves alignment back one bit.
        offset = 3; nslip = 0; lock_at = -1;
        for (int i = 0; i < 4; i++) slip_at[i] = 0;
        for (int t = 1; t <= 200 && lock_at < 0; t++) begin
            drive(rot(CTL0, offset));
            if (bus.bitslip) begin
                if (nslip < 4) slip_at[nslip] = t;
                nslip++;
                offset = (offset + 9) % 10;
            end
            if (bus.locked) lock_at = t;
        end
        chk("t3_lock_seen", lock_at >= 0, 1);
        chk("t3_slips", nslip, 3);
        chk("t3_first_slip", slip_at[0], 32);
        chk("t3_gap1", slip_at[1] - slip_at[0], 36);
        chk("t3_gap2", slip_at[2] - slip_at[1], 36);
        chk("t3_lock_delay", lock_at - slip_at[2], 8);
        drive(tmds_encode(8'h3C));
        chk("t3_vd", bus.VD, 8'h3C);
        chk("t3_vde", bus.VDE, 1);

        // Random mix of token bursts, encoded video and raw words.
        for (int seg = 0; seg < 140; seg++) begin
            if (seg == 70) do_reset();
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                len = $urandom_range(1, 10);
                repeat (len) drive(ctl_words[$urandom_range(0, 3)]);
            end else if (kind < 8) begin
                len = $urandom_range(1, 80);
                repeat (len) drive(tmds_encode(8'($urandom_range(0, 255))));
            end else begin
                len = $urandom_range(1, 6);
                repeat (len) drive(10'($urandom_range(0, 1023)));
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
